sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised, pipelined sprite layer for the VGA path. Takes the raster position plus a background colour, tests N sprites for hits, and drives one address per sprite to external synchronous sprite ROMs. It merges the returned texels over the background using fixed priority and a transparent key, and outputs one registered colour per pixel. It sits between the tile/background generator and the VGA pin drivers, and replaces per-sprite hand-written hit logic.

## Interface
- NUM_SPRITES, 4: sprite count; index 0 has highest priority (player).
- SPRITE_W, 32: sprite width in pixels.
- SPRITE_H, 32: sprite height in pixels.
- COORD_W, 10: width of raster and sprite coordinates.
- COLOR_W, 9: colour width, packed {B[2:0], G[2:0], R[2:0]}.
- ADDR_W, 10: ROM address width; must be ≥ clog2(SPRITE_W*SPRITE_H).
- H_DISPLAY, 640: active width.
- V_DISPLAY, 480: active height.
- TRANSPARENT, 0: texel value treated as see-through.

Ports:
- CLK  in  1  pixel clock; one clock domain.
- RST  in  1  asynchronous, active-high reset.
- h_count  in  COORD_W  raster x.
- v_count  in  COORD_W  raster y.
- frame_start  in  1  one-cycle pulse when h_count=0 and v_count=0.
- bg_color  in  COLOR_W  background colour for the current h_count/v_count, same cycle.
- sprite_x  in  NUM_SPRITES*COORD_W  packed left edges; sprite i at [i*COORD_W +: COORD_W].
- sprite_y  in  NUM_SPRITES*COORD_W  packed top edges.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_mirror  in  NUM_SPRITES  per-sprite horizontal flip.
- rom_addr  out  NUM_SPRITES*ADDR_W  registered texel address per sprite.
- rom_data  in  NUM_SPRITES*COLOR_W  texel from each ROM, valid one cycle after rom_addr.
- pixel  out  COLOR_W  composited colour.
- pixel_de  out  1  pixel is in the active area.
- collision_mask  out  NUM_SPRITES  per-frame collision flags; present only with SPRITE_COLLISION_EN.

## Operation
- Sprite i hits when all of the following hold:
  - sprite_en[i]=1.
  - sprite_x[i] ≤ h_count < sprite_x[i]+SPRITE_W.
  - sprite_y[i] ≤ v_count < sprite_y[i]+SPRITE_H.
  - The sums are computed at COORD_W+1 bits, so a sprite near the edge of the coordinate range never wraps.
- Address for a hitting sprite is dy*SPRITE_W + dx, where dy=v_count−sprite_y[i].
  - Unmirrored: dx = h_count−sprite_x[i].
  - Mirrored: dx = SPRITE_W−1−(h_count−sprite_x[i]).
  - A non-hitting sprite drives rom_addr 0.
- The active area is h_count<H_DISPLAY and v_count<V_DISPLAY. Outside it, no sprite hits, pixel=0 and pixel_de=0.
- Compositing:
  - Take the lowest-index sprite that both hit and returned a texel ≠ TRANSPARENT.
  - If there is none, output the delayed bg_color.
- Sprite coordinates, enables and mirror flags are sampled every cycle. Software updates them during vertical blank; the block does not latch them per frame.

## Timing
- The pipeline has 3 stages, and the pixel for the h_count/v_count sampled at edge n is valid after edge n+3:
  - S1 (edge n+1): rom_addr, hit vector, active flag and bg_color registered.
  - S2 (edge n+2): external ROM registers data; hit, active and bg are delayed once more.
  - S3 (edge n+3): priority merge; pixel and pixel_de registered.
- The delayed hit/active/bg values stay aligned with rom_data exactly; no bubbles, and throughput is one pixel per clock.
- Reset (RST high, asynchronous):
  - pixel=0, pixel_de=0, rom_addr=0, collision_mask=0.
  - All pipeline hit/active bits are cleared.
  - After release, outputs stay 0 until real data reaches S3, three edges later.
- Reset asserted mid-line clears outputs immediately; no partial pixel escapes.

## Configuration
- SPRITE_COLLISION_EN defined: per-frame pixel-exact collision detection.
  - In S3, if sprite 0 and sprite k (k≥1) are both hit and opaque on the same pixel, sticky accumulator bit k is set.
  - On frame_start, collision_mask ← accumulator and the accumulator clears. A hit in the same cycle as frame_start lands in the new accumulator.
  - collision_mask[0] is always 0.
  - collision_mask is stable for a whole frame.
- SPRITE_COLLISION_EN undefined: no accumulator, and the collision_mask port is absent. All other behaviour is identical.

## Test plan
- Reset and latency:
  - Stimulus: assert RST mid-frame, release, drive bg_color=9'h0A5 with no sprites enabled.
  - Required: pixel=0 and pixel_de=0 during reset; pixel=9'h0A5 and pixel_de=1 exactly 3 cycles after the first active h_count.
- Single sprite with ROM model:
  - Stimulus: sprite 1 at (100,50); ROM returns its address as data.
  - Required: at h=105, v=52 the pixel 3 cycles later equals 2*32+5=69.
  - Required: h=132 shows bg_color (right edge exclusive).
- Mirror:
  - Stimulus: same sprite as above with sprite_mirror[1]=1.
  - Required: h=100 gives address 31; h=131 gives address 0.
- Priority and transparency:
  - Stimulus: sprites 0 and 2 overlap.
  - Required: sprite 0 texel 9'h1FF is output.
  - Required: where sprite 0 texel=0, sprite 2 texel 9'h038 shows instead.
  - Required: where both texels are 0, bg_color shows.
- Clipping:
  - Stimulus: sprite at x=630.
  - Required: it is visible for h=630..639, pixel_de=0 from h=640, and no wrap to h=0.
- Collision (SPRITE_COLLISION_EN):
  - Stimulus: opaque overlap of sprites 0 and 3 in frame F.
  - Required: collision_mask=4'b1000 after the frame_start following F, and 0 after the next frame_start if there is no overlap.

Source files
------------

// File: rtl/sprite_compositor.sv
// Pipelined N-sprite compositor: hit test and ROM addressing, external ROM read, then priority merge over the background.
// Optional feature macro SPRITE_COLLISION_EN adds per-frame sprite-0 collision flags on collision_mask.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 9,
  parameter int ADDR_W      = 10,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int TRANSPARENT = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [COORD_W-1:0]             h_count,
  input  logic [COORD_W-1:0]             v_count,
  input  logic                           frame_start,
  input  logic [COLOR_W-1:0]             bg_color,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [NUM_SPRITES-1:0]         sprite_mirror,
  output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
  input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]             pixel,
  output logic                           pixel_de
`ifdef SPRITE_COLLISION_EN
  ,
  output logic [NUM_SPRITES-1:0]         collision_mask
`endif
);

  localparam logic [COORD_W:0] H_LIM   = (COORD_W+1)'(H_DISPLAY);
  localparam logic [COORD_W:0] V_LIM   = (COORD_W+1)'(V_DISPLAY);
  localparam logic [COLOR_W-1:0] T_KEY = COLOR_W'(TRANSPARENT);

  logic                          active0;
  logic [NUM_SPRITES-1:0]        hit0;
  logic [NUM_SPRITES*ADDR_W-1:0] addr0;

  logic                          s1_active, s2_active;
  logic [NUM_SPRITES-1:0]        s1_hit, s2_hit;
  logic [COLOR_W-1:0]            s1_bg, s2_bg;

  logic [NUM_SPRITES-1:0]        opaque;
  logic [COLOR_W-1:0]            merged;

  assign active0 = ({1'b0, h_count} < H_LIM) && ({1'b0, v_count} < V_LIM);

  // Edge sums are one bit wider than the coordinates so sprites near the top of the range never wrap.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
    logic [COORD_W-1:0] sx, sy, dx, dy, dx_eff;
    logic [COORD_W:0]   x_end, y_end;
    logic               in_x, in_y;

    assign sx     = sprite_x[g*COORD_W +: COORD_W];
    assign sy     = sprite_y[g*COORD_W +: COORD_W];
    assign x_end  = {1'b0, sx} + (COORD_W+1)'(SPRITE_W);
    assign y_end  = {1'b0, sy} + (COORD_W+1)'(SPRITE_H);
    assign in_x   = (h_count >= sx) && ({1'b0, h_count} < x_end);
    assign in_y   = (v_count >= sy) && ({1'b0, v_count} < y_end);
    assign dx     = h_count - sx;
    assign dy     = v_count - sy;
    assign dx_eff = sprite_mirror[g] ? (COORD_W'(SPRITE_W - 1) - dx) : dx;

    assign hit0[g] = active0 && sprite_en[g] && in_x && in_y;
    assign addr0[g*ADDR_W +: ADDR_W] = hit0[g] ?
        (ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx_eff)) : '0;

    assign opaque[g] = s2_hit[g] && (rom_data[g*COLOR_W +: COLOR_W] != T_KEY);
  end

  // Walk from lowest to highest priority so the lowest opaque index is the last writer.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    merged = s2_bg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) merged = rom_data[i*COLOR_W +: COLOR_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_active <= 1'b0;
      s1_hit    <= '0;
      s1_bg     <= '0;
      rom_addr  <= '0;
      s2_active <= 1'b0;
      s2_hit    <= '0;
      s2_bg     <= '0;
      pixel     <= '0;
      pixel_de  <= 1'b0;
    end else begin
      s1_active <= active0;
      s1_hit    <= hit0;
      s1_bg     <= bg_color;
      rom_addr  <= addr0;
      s2_active <= s1_active;
      s2_hit    <= s1_hit;
      s2_bg     <= s1_bg;
      pixel     <= s2_active ? merged : '0;
      pixel_de  <= s2_active;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] coll_now, coll_acc;

  always_comb begin
    coll_now = '0;
    for (int k = 1; k < NUM_SPRITES; k++) coll_now[k] = opaque[0] & opaque[k];
  end

  // A collision seen on the frame_start cycle belongs to the frame that is starting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      coll_acc       <= '0;
      collision_mask <= '0;
    end else if (frame_start) begin
      collision_mask <= coll_acc;
      coll_acc       <= coll_now;
    end else begin
      coll_acc       <= coll_acc | coll_now;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset/latency, addressing, mirror, priority, clipping, and collision when enabled.
module tb_sprite_compositor;

  localparam int NS = 4;
  localparam int CW = 10;
  localparam int KW = 9;
  localparam int AW = 10;

  logic              CLK = 1'b0;
  logic              RST;
  logic [CW-1:0]     h_count, v_count;
  logic              frame_start;
  logic [KW-1:0]     bg_color;
  logic [NS*CW-1:0]  sprite_x, sprite_y;
  logic [NS-1:0]     sprite_en, sprite_mirror;
  logic [NS*AW-1:0]  rom_addr;
  logic [NS*KW-1:0]  rom_data;
  logic [KW-1:0]     pixel;
  logic              pixel_de;
`ifdef SPRITE_COLLISION_EN
  logic [NS-1:0]     collision_mask;
`endif

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;

  sprite_compositor dut (
    .CLK           (CLK),
    .RST           (RST),
    .h_count       (h_count),
    .v_count       (v_count),
    .frame_start   (frame_start),
    .bg_color      (bg_color),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .sprite_en     (sprite_en),
    .sprite_mirror (sprite_mirror),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pixel         (pixel),
    .pixel_de      (pixel_de)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision_mask(collision_mask)
`endif
  );

  always #5 CLK = ~CLK;

  // Mode 0: texel = address; mode 1: striped sprites 0 and 2; otherwise every texel opaque 9'h007.
  function automatic logic [KW-1:0] texel(input int s, input logic [AW-1:0] a);
    case (rom_mode)
      0: return a[KW-1:0];
      1: begin
        if (s == 0) return (a[4:0] < 5'd8)  ? 9'h1FF : 9'h000;
        if (s == 2) return (a[4:0] < 5'd16) ? 9'h038 : 9'h000;
        return 9'h000;
      end
      default: return 9'h007;
    endcase
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < NS; i++) rom_data[i*KW +: KW] <= texel(i, rom_addr[i*AW +: AW]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input logic en, input logic mir);
    sprite_x[i*CW +: CW] = CW'(x);
    sprite_y[i*CW +: CW] = CW'(y);
    sprite_en[i]         = en;
    sprite_mirror[i]     = mir;
  endtask

  task automatic drive(input int h, input int v, input logic [KW-1:0] bg);
    @(negedge CLK);
    h_count  = CW'(h);
    v_count  = CW'(v);
    bg_color = bg;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_frame_start();
    @(negedge CLK);
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    h_count = '0; v_count = '0; frame_start = 1'b0; bg_color = '0;
    sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_mirror = '0;
    rom_data = '0;
    run(3);
    check("reset_pixel", 32'(pixel), 32'h0);
    check("reset_de", 32'(pixel_de), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Get a live sprite pixel through the pipe, then reset in the middle of it.
    set_sprite(1, 5, 5, 1'b1, 1'b0);
    drive(10, 10, 9'h123);
    run(4);
    check("pre_reset_pixel", 32'(pixel), 32'd165);
    check("pre_reset_addr", 32'(rom_addr[1*AW +: AW]), 32'd165);
    #2 RST = 1'b1;
    #1;
    check("async_reset_pixel", 32'(pixel), 32'h0);
    check("async_reset_de", 32'(pixel_de), 32'h0);
    check("async_reset_addr", 32'(rom_addr), 32'h0);

    // Release with nothing enabled and check the three-edge latency of the first active pixel.
    sprite_en = '0;
    drive(700, 0, 9'h0A5);
    RST = 1'b0;
    run(4);
    check("idle_inactive_de", 32'(pixel_de), 32'h0);
    drive(0, 0, 9'h0A5);
    run(1);
    check("lat_edge1_de", 32'(pixel_de), 32'h0);
    run(1);
    check("lat_edge2_de", 32'(pixel_de), 32'h0);
    run(1);
    check("lat_edge3_de", 32'(pixel_de), 32'h1);
    check("lat_edge3_pixel", 32'(pixel), 32'h0A5);

    // Single sprite 1 at (100,50), texel = address.
    rom_mode = 0;
    set_sprite(1, 100, 50, 1'b1, 1'b0);
    drive(105, 52, 9'h0F0);
    run(3);
    check("single_pixel", 32'(pixel), 32'd69);
    check("single_addr", 32'(rom_addr[1*AW +: AW]), 32'd69);
    drive(131, 52, 9'h0F0);
    run(3);
    check("single_last_col", 32'(pixel), 32'd95);
    drive(132, 52, 9'h0F0);
    run(3);
    check("single_right_excl", 32'(pixel), 32'h0F0);
    check("single_right_addr", 32'(rom_addr[1*AW +: AW]), 32'h0);
    drive(99, 52, 9'h0F0);
    run(3);
    check("single_left_outside", 32'(pixel), 32'h0F0);
    drive(105, 82, 9'h0F0);
    run(3);
    check("single_bottom_excl", 32'(pixel), 32'h0F0);

    // Mirror: first column reads texel 31, last column texel 0 (transparent).
    set_sprite(1, 100, 50, 1'b1, 1'b1);
    drive(100, 50, 9'h0F0);
    run(3);
    check("mirror_left_addr", 32'(rom_addr[1*AW +: AW]), 32'd31);
    check("mirror_left_pixel", 32'(pixel), 32'd31);
    drive(131, 50, 9'h0F0);
    run(3);
    check("mirror_right_addr", 32'(rom_addr[1*AW +: AW]), 32'd0);
    check("mirror_right_pixel", 32'(pixel), 32'h0F0);

    // Priority: sprites 0 and 2 overlap at (200,100).
    rom_mode = 1;
    set_sprite(1, 0, 0, 1'b0, 1'b0);
    set_sprite(0, 200, 100, 1'b1, 1'b0);
    set_sprite(2, 200, 100, 1'b1, 1'b0);
    drive(203, 100, 9'h00C);
    run(3);
    check("prio_sprite0", 32'(pixel), 32'h1FF);
    drive(210, 100, 9'h00C);
    run(3);
    check("prio_sprite2_through", 32'(pixel), 32'h038);
    drive(220, 100, 9'h00C);
    run(3);
    check("prio_both_clear", 32'(pixel), 32'h00C);
    sprite_en[2] = 1'b0;
    drive(210, 100, 9'h00C);
    run(3);
    check("prio_sprite2_disabled", 32'(pixel), 32'h00C);

    // Clipping at the right edge of the active area.
    rom_mode = 0;
    sprite_en = '0;
    set_sprite(0, 630, 0, 1'b1, 1'b0);
    drive(635, 5, 9'h011);
    run(3);
    check("clip_inside", 32'(pixel), 32'd165);
    drive(639, 5, 9'h011);
    run(3);
    check("clip_last_col", 32'(pixel), 32'd169);
    check("clip_last_de", 32'(pixel_de), 32'h1);
    drive(640, 5, 9'h011);
    run(3);
    check("clip_beyond_de", 32'(pixel_de), 32'h0);
    check("clip_beyond_pixel", 32'(pixel), 32'h0);
    check("clip_beyond_addr", 32'(rom_addr[0 +: AW]), 32'h0);
    drive(0, 5, 9'h011);
    run(3);
    check("clip_no_wrap", 32'(pixel), 32'h011);
    drive(635, 480, 9'h011);
    run(3);
    check("clip_vblank_de", 32'(pixel_de), 32'h0);

`ifdef SPRITE_COLLISION_EN
    // Opaque overlap of sprites 0 and 3 in one frame, none in the next.
    rom_mode = 2;
    sprite_en = '0;
    set_sprite(0, 300, 200, 1'b1, 1'b0);
    set_sprite(3, 300, 200, 1'b1, 1'b0);
    drive(0, 0, 9'h000);
    run(4);
    pulse_frame_start();
    drive(305, 205, 9'h000);
    run(4);
    check("coll_overlap_pixel", 32'(pixel), 32'h007);
    drive(0, 0, 9'h000);
    run(4);
    pulse_frame_start();
    #1;
    check("coll_mask_set", 32'(collision_mask), 32'h8);
    run(6);
    check("coll_mask_stable", 32'(collision_mask), 32'h8);
    pulse_frame_start();
    #1;
    check("coll_mask_cleared", 32'(collision_mask), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
